bcd3_to_bin: RTL

Sequential decimal-to-binary converter: accepts three BCD digits (units, tens, hundreds) on a start strobe and produces the 10-bit binary value after one multiply-by-ten-and-add step per digit. It is the inverse of the display path's binary-to-digits conversion. It sits between keypad/switch digit entry and the arithmetic datapath.

---
 rtl/bcd3_to_bin_pkg.sv | 16 +
 rtl/bcd3_to_bin_if.sv | 25 ++
 rtl/bcd3_to_bin_mul10_add.sv | 14 +
 rtl/bcd3_to_bin.sv | 108 ++++++++++
 4 files changed

// File: rtl/bcd3_to_bin_pkg.sv
// Shared constants and state encoding for the BCD-to-binary converter.
package bcd3_to_bin_pkg;

  typedef enum logic {
    StIdle,
    StConv
  } state_e;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned N_DIGITS = 3;
  localparam int unsigned BIN_W    = 10;

  localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;
  localparam int unsigned        MAX_VALUE     = 999;

endpackage

// File: rtl/bcd3_to_bin_if.sv
// Request/result bundle for bcd3_to_bin. The error line exists only when
// BCD_CHECK_EN is defined.
interface bcd3_to_bin_if #(
  parameter int unsigned BIN_W = bcd3_to_bin_pkg::BIN_W
);
  import bcd3_to_bin_pkg::*;

  logic               start;
  logic [DIGIT_W-1:0] h1;
  logic [DIGIT_W-1:0] h2;
  logic [DIGIT_W-1:0] h3;
  logic               busy;
  logic               done;
  logic [BIN_W-1:0]   salida;
`ifdef BCD_CHECK_EN
  logic               error;

  modport master (output start, h1, h2, h3, input busy, done, salida, error);
  modport slave  (input start, h1, h2, h3, output busy, done, salida, error);
`else
  modport master (output start, h1, h2, h3, input busy, done, salida);
  modport slave  (input start, h1, h2, h3, output busy, done, salida);
`endif

endinterface

// File: rtl/bcd3_to_bin_mul10_add.sv
// Combinational acc*10 + digit, truncated to BIN_W. The multiply is built from
// two shifts so no multiplier is inferred.
module bcd3_to_bin_mul10_add #(
  parameter int unsigned BIN_W   = 10,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic [BIN_W-1:0]   acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [BIN_W-1:0]   result
);

  assign result = (acc << 3) + (acc << 1) + BIN_W'(digit);

endmodule

// File: rtl/bcd3_to_bin.sv
// Sequential three-digit BCD to binary converter: one multiply-by-ten-and-add
// step per clock, hundreds first. Optional digit range check under the macro
// BCD_CHECK_EN (adds the error output; bad input forces salida to 0).
module bcd3_to_bin
  import bcd3_to_bin_pkg::*;
#(
  parameter int unsigned N_DIGITS = bcd3_to_bin_pkg::N_DIGITS,
  parameter int unsigned BIN_W    = bcd3_to_bin_pkg::BIN_W
) (
  input logic          clk,
  input logic          reset_n,
  bcd3_to_bin_if.slave bus
);

  localparam logic [1:0] LastStep = 2'(N_DIGITS - 1);

  state_e             state_q;
  logic [1:0]         step_q;
  logic [DIGIT_W-1:0] digit_q [N_DIGITS];
  logic [BIN_W-1:0]   acc_q;
  logic [BIN_W-1:0]   acc_next;
  logic               busy_q;
  logic               done_q;
  logic [BIN_W-1:0]   salida_q;

  bcd3_to_bin_mul10_add #(
    .BIN_W   (BIN_W),
    .DIGIT_W (DIGIT_W)
  ) u_mul10_add (
    .acc    (acc_q),
    .digit  (digit_q[step_q]),
    .result (acc_next)
  );

`ifdef BCD_CHECK_EN
  logic bad_digit;
  logic err_flag_q;
  logic error_q;

  // Flag any non-decimal digit on the inputs being accepted.
  always_comb begin
    bad_digit = (bus.h1 > BCD_MAX_DIGIT) | (bus.h2 > BCD_MAX_DIGIT) |
                (bus.h3 > BCD_MAX_DIGIT);
  end
`endif

  // Control FSM, digit latch, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      step_q     <= '0;
      digit_q    <= '{default: '0};
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      salida_q   <= '0;
`ifdef BCD_CHECK_EN
      err_flag_q <= 1'b0;
      error_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            // digit_q[0] is consumed first, so it holds the hundreds digit.
            digit_q[0] <= bus.h3;
            digit_q[1] <= bus.h2;
            digit_q[2] <= bus.h1;
            acc_q      <= '0;
            step_q     <= '0;
            busy_q     <= 1'b1;
            state_q    <= StConv;
`ifdef BCD_CHECK_EN
            err_flag_q <= bad_digit;
            error_q    <= 1'b0;
`endif
          end
        end
        StConv: begin
          if (step_q == LastStep) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`ifdef BCD_CHECK_EN
            error_q  <= err_flag_q;
            salida_q <= err_flag_q ? '0 : acc_next;
`else
            salida_q <= acc_next;
`endif
          end else begin
            acc_q  <= acc_next;
            step_q <= step_q + 2'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.salida = salida_q;
`ifdef BCD_CHECK_EN
  assign bus.error  = error_q;
`endif

endmodule
